// File: rtl/datapath_pipe_if.sv
// Bundle between control decode, the data-memory port and datapath_pipe.
// The master side drives instructions and load data; the slave side is the datapath.
interface datapath_pipe_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [AW-1:0]    rs;
    logic [AW-1:0]    rt;
    logic [AW-1:0]    rd;
    logic             reg_dst;
    logic             alu_src;
    logic             shift_amt;
    logic [15:0]      imm;
    logic             imm_zext;
    logic [4:0]       shamt;
    logic             link;
    logic [WIDTH-1:0] pc;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_rdata;
    logic [WIDTH-1:0] read_data_0;
    logic             out_valid;
    logic [WIDTH-1:0] alu_out;
    logic             z;
    logic             n;
    logic [WIDTH-1:0] register_v0;

    modport master (
        output in_valid, op, rs, rt, rd, reg_dst, alu_src, shift_amt, imm, imm_zext,
               shamt, link, pc, reg_write, mem_to_reg, mem_ready, mem_rdata,
        input  in_ready, read_data_0, out_valid, alu_out, z, n, register_v0
    );

    modport slave (
        input  in_valid, op, rs, rt, rd, reg_dst, alu_src, shift_amt, imm, imm_zext,
               shamt, link, pc, reg_write, mem_to_reg, mem_ready, mem_rdata,
        output in_ready, read_data_0, out_valid, alu_out, z, n, register_v0
    );
endinterface

// File: rtl/datapath_pipe.sv
// Register file, operand select, ALU and a one-deep execute/writeback register
// with writeback forwarding, link writes and a load-wait stall.
module datapath_pipe #(
    parameter int WIDTH       = 32,
    parameter int NREGS       = 32,
    parameter int LINK_REG    = NREGS - 1,
    parameter int LINK_OFFSET = 8
) (
    input  logic            clk,
    input  logic            reset,
    datapath_pipe_if.slave  bus
);
    localparam int AW  = $clog2(NREGS);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] w_rf [NREGS];

    logic             r_valid;
    logic             r_we;
    logic             r_m2r;
    logic [AW-1:0]    r_dest;
    logic [WIDTH-1:0] r_alu;
    logic             r_z;
    logic             r_n;

    logic             w_stall;
    logic             w_issue;
    logic             w_fwd_en;
    logic             w_commit;
    logic [WIDTH-1:0] w_wb_data;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_rt;
    logic [WIDTH-1:0] w_op_b;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_result;
    logic [AW-1:0]    w_dest;

    // A load sitting in writeback without data blocks both the commit and new issue.
    assign w_stall   = r_valid && r_m2r && !bus.mem_ready;
    assign w_issue   = bus.in_valid && bus.in_ready;
    assign w_wb_data = r_m2r ? bus.mem_rdata : r_alu;
    assign w_fwd_en  = r_valid && r_we && (r_dest != '0);
    assign w_commit  = w_fwd_en && !(r_m2r && !bus.mem_ready);

    assign w_op_a  = (w_fwd_en && bus.rs == r_dest) ? w_wb_data : w_rf[bus.rs];
    assign w_op_rt = (w_fwd_en && bus.rt == r_dest) ? w_wb_data : w_rf[bus.rt];

    always_comb begin
        w_op_b = w_op_rt;
        if (bus.alu_src) begin
            if (bus.shift_amt)
                w_op_b = WIDTH'(bus.shamt);
            else if (bus.imm_zext)
                w_op_b = WIDTH'(bus.imm);
            else
                w_op_b = WIDTH'($signed(bus.imm));
        end
    end

    assign w_sh = w_op_b[SHW-1:0];

    always_comb begin
        w_alu = w_op_a + w_op_b;
        case (bus.op)
            4'd1:    w_alu = w_op_a - w_op_b;
            4'd2:    w_alu = w_op_a & w_op_b;
            4'd3:    w_alu = w_op_a | w_op_b;
            4'd4:    w_alu = w_op_a ^ w_op_b;
            4'd5:    w_alu = w_op_a << w_sh;
            4'd6:    w_alu = w_op_a >> w_sh;
            4'd7:    w_alu = $unsigned($signed(w_op_a) >>> w_sh);
            4'd8:    w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            4'd9:    w_alu = {{(WIDTH-1){1'b0}}, (w_op_a < w_op_b)};
            4'd10:   w_alu = WIDTH'({bus.imm, 16'h0000});
            default: w_alu = w_op_a + w_op_b;
        endcase
    end

    assign w_result = bus.link ? (bus.pc + WIDTH'(LINK_OFFSET)) : w_alu;
    assign w_dest   = bus.link ? AW'(LINK_REG) : (bus.reg_dst ? bus.rd : bus.rt);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_m2r   <= 1'b0;
            r_dest  <= '0;
            r_alu   <= '0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
        end else if (!w_stall) begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_we   <= bus.link || bus.reg_write;
                r_m2r  <= !bus.link && bus.mem_to_reg;
                r_dest <= w_dest;
                r_alu  <= w_result;
                r_z    <= (w_result == '0);
                r_n    <= w_result[WIDTH-1];
            end
        end
    end

    // Register 0 is a hard-wired zero; every other entry is its own register.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
        if (gi == 0) begin : g_zero
            assign w_rf[gi] = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] r_q;
            always_ff @(posedge clk) begin
                if (!reset)
                    r_q <= '0;
                else if (w_commit && r_dest == AW'(gi))
                    r_q <= w_wb_data;
            end
            assign w_rf[gi] = r_q;
        end
    end

    assign bus.in_ready    = reset && !w_stall;
    assign bus.read_data_0 = w_op_a;
    assign bus.out_valid   = r_valid;
    assign bus.alu_out     = r_alu;
    assign bus.z           = r_z;
    assign bus.n           = r_n;
    assign bus.register_v0 = w_rf[2];
endmodule

// File: tb/tb_datapath_pipe.sv
// Randomised scoreboard bench for datapath_pipe: a sequential-semantics model
// predicts each result at issue; a monitor checks them as writeback completes.
module tb_datapath_pipe;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    datapath_pipe_if #(.WIDTH(32), .AW(5)) bus ();
    datapath_pipe_if #(.WIDTH(16), .AW(4)) bus16 ();

    datapath_pipe #(.WIDTH(32), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    datapath_pipe #(.WIDTH(16), .NREGS(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic        reg_dst, alu_src, shift_amt, imm_zext, link, reg_write, mem_to_reg;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic [31:0] pc;
        logic [31:0] ld_data;
        int          ld_wait;
    } instr_t;

    int n_checks = 0;
    int n_pass   = 0;
    int n_wb     = 0;

    logic [31:0] model_rf [32];
    logic [33:0] sb [$];
    bit          wb_is_load = 0;
    int          pend_wait  = 0;
    logic [31:0] pend_data  = '0;
    int          last_tries = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic instr_t nop();
        instr_t t;
        t.op = 4'd0; t.rs = 5'd0; t.rt = 5'd0; t.rd = 5'd0;
        t.reg_dst = 0; t.alu_src = 0; t.shift_amt = 0; t.imm_zext = 0;
        t.link = 0; t.reg_write = 0; t.mem_to_reg = 0;
        t.imm = 16'h0; t.shamt = 5'd0; t.pc = 32'h0; t.ld_data = 32'h0; t.ld_wait = 0;
        return t;
    endfunction

    function automatic instr_t r_type(input logic [3:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt);
        instr_t t = nop();
        t.op = op; t.rd = rd; t.rs = rs; t.rt = rt; t.reg_dst = 1; t.reg_write = 1;
        return t;
    endfunction

    function automatic instr_t i_type(input logic [3:0] op, input logic [4:0] rt,
                                      input logic [4:0] rs, input logic [15:0] imm, input logic zx);
        instr_t t = nop();
        t.op = op; t.rt = rt; t.rs = rs; t.imm = imm; t.imm_zext = zx;
        t.alu_src = 1; t.reg_write = 1;
        return t;
    endfunction

    function automatic instr_t shift_i(input logic [3:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] sa);
        instr_t t = nop();
        t.op = op; t.rd = rd; t.rs = rs; t.shamt = sa;
        t.alu_src = 1; t.shift_amt = 1; t.reg_dst = 1; t.reg_write = 1;
        return t;
    endfunction

    function automatic logic [31:0] ref_alu(input instr_t t, input logic [31:0] a, input logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        case (t.op)
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << s;
            4'd6:  return a >> s;
            4'd7:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return {t.imm, 16'h0000};
            default: return a + b;
        endcase
    endfunction

    task automatic apply_model(input instr_t t);
        logic [31:0] a, b, res;
        logic [4:0]  dest;
        logic        we, m2r;
        a = model_rf[t.rs];
        if (!t.alu_src)       b = model_rf[t.rt];
        else if (t.shift_amt) b = {27'h0, t.shamt};
        else if (t.imm_zext)  b = {16'h0, t.imm};
        else                  b = {{16{t.imm[15]}}, t.imm};
        res  = t.link ? t.pc + 32'd8 : ref_alu(t, a, b);
        dest = t.link ? 5'd31 : (t.reg_dst ? t.rd : t.rt);
        we   = t.link || t.reg_write;
        m2r  = t.mem_to_reg && !t.link;
        sb.push_back({res[31], (res == 32'h0), res});
        if (we && dest != 5'd0) model_rf[dest] = m2r ? t.ld_data : res;
    endtask

    task automatic cycle(input bit v, input instr_t t, output bit acc);
        logic mr;
        @(negedge clk);
        if (wb_is_load && pend_wait > 0) begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            pend_wait--;
        end else begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = wb_is_load ? pend_data : $urandom;
        end
        bus.op = t.op; bus.rs = t.rs; bus.rt = t.rt; bus.rd = t.rd;
        bus.reg_dst = t.reg_dst; bus.alu_src = t.alu_src; bus.shift_amt = t.shift_amt;
        bus.imm = t.imm; bus.imm_zext = t.imm_zext; bus.shamt = t.shamt;
        bus.link = t.link; bus.pc = t.pc; bus.reg_write = t.reg_write;
        bus.mem_to_reg = t.mem_to_reg; bus.in_valid = v;
        #1;
        acc = v && (bus.in_ready === 1'b1);
        if (acc) check("read_data_0", bus.read_data_0, model_rf[t.rs]);
        mr = bus.mem_ready;
        @(posedge clk);
        if (mr) begin
            wb_is_load = acc && t.mem_to_reg && !t.link;
            if (acc) begin
                pend_wait = t.ld_wait;
                pend_data = t.ld_data;
            end
        end
        if (acc) apply_model(t);
    endtask

    task automatic send(input instr_t t);
        int tries = 0;
        bit acc = 0;
        while (!acc && tries < 20) begin
            cycle(1'b1, t, acc);
            tries++;
        end
        if (!acc) check("issue_timeout", 32'd0, 32'd1);
        last_tries = tries;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(1'b0, nop(), acc);
    endtask

    task automatic check_reg(input int idx, input logic [31:0] exp);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        bus.rs        = 5'(idx);
        wb_is_load    = 0;
        #1;
        check($sformatf("reg_r%0d", idx), bus.read_data_0, exp);
    endtask

    // Monitor: one writeback retires whenever the stage is occupied and not stalled.
    always begin
        @(negedge clk);
        #2;
        if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.in_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                logic [33:0] e;
                e = sb.pop_front();
                n_wb++;
                $display("wb %0d: alu_out=%h z=%b n=%b (exp %h z=%b n=%b)",
                         n_wb, bus.alu_out, bus.z, bus.n, e[31:0], e[32], e[33]);
                check("alu_out", bus.alu_out, e[31:0]);
                check("z_flag", {31'h0, bus.z}, {31'h0, e[32]});
                check("n_flag", {31'h0, bus.n}, {31'h0, e[33]});
            end
        end
    end

    initial begin
        instr_t t;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
        t = nop();
        bus.in_valid = 0; bus.mem_ready = 1; bus.mem_rdata = '0;
        bus.op = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.reg_dst = 0;
        bus.alu_src = 0; bus.shift_amt = 0; bus.imm = '0; bus.imm_zext = 0;
        bus.shamt = '0; bus.link = 0; bus.pc = '0; bus.reg_write = 0; bus.mem_to_reg = 0;
        bus16.in_valid = 0; bus16.mem_ready = 1; bus16.mem_rdata = '0;
        bus16.op = '0; bus16.rs = '0; bus16.rt = '0; bus16.rd = '0; bus16.reg_dst = 0;
        bus16.alu_src = 0; bus16.shift_amt = 0; bus16.imm = '0; bus16.imm_zext = 0;
        bus16.shamt = '0; bus16.link = 0; bus16.pc = '0; bus16.reg_write = 0; bus16.mem_to_reg = 0;

        // Reset held low for two edges.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_alu_out", bus.alu_out, 32'h0);
        check("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
        check("rst_z", {31'h0, bus.z}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        for (int i = 0; i < 32; i++) check_reg(i, 32'h0);

        // Back-to-back dependency.
        send(i_type(4'd0, 5'd1, 5'd0, 16'h0005, 1'b0));
        send(r_type(4'd0, 5'd2, 5'd1, 5'd1));
        idle(1);
        #1;
        check("register_v0", bus.register_v0, 32'd10);

        // Load with three wait cycles, then a dependent add.
        t = i_type(4'd0, 5'd3, 5'd0, 16'h0100, 1'b0);
        t.mem_to_reg = 1; t.ld_wait = 3; t.ld_data = 32'hDEAD_BEEF;
        send(t);
        send(r_type(4'd0, 5'd4, 5'd3, 5'd0));
        check("stall_cycles", 32'(last_tries - 1), 32'd3);

        t = nop(); t.link = 1; t.pc = 32'h0040_0010;
        send(t);
        send(i_type(4'd0, 5'd0, 5'd0, 16'h0007, 1'b0));
        send(r_type(4'd0, 5'd5, 5'd0, 5'd0));

        send(i_type(4'd10, 5'd6, 5'd0, 16'h8000, 1'b0));
        send(shift_i(4'd7, 5'd7, 5'd6, 5'd4));
        send(i_type(4'd0, 5'd8, 5'd0, 16'hFFFF, 1'b0));
        send(i_type(4'd3, 5'd9, 5'd0, 16'hFFFF, 1'b1));
        send(i_type(4'd0, 5'd10, 5'd0, 16'h0001, 1'b0));
        send(r_type(4'd8, 5'd11, 5'd8, 5'd10));
        send(r_type(4'd9, 5'd12, 5'd8, 5'd10));
        send(i_type(4'd10, 5'd13, 5'd0, 16'h8000, 1'b0));
        send(i_type(4'd0, 5'd13, 5'd13, 16'hFFFF, 1'b0));
        send(r_type(4'd0, 5'd14, 5'd13, 5'd10));
        idle(2);

        check_reg(0, 32'h0);
        check_reg(2, 32'd10);
        check_reg(4, 32'hDEAD_BEEF);
        check_reg(5, 32'h0);
        check_reg(7, 32'hF800_0000);
        check_reg(8, 32'hFFFF_FFFF);
        check_reg(9, 32'h0000_FFFF);
        check_reg(11, 32'h1);
        check_reg(12, 32'h0);
        check_reg(14, 32'h8000_0000);
        check_reg(31, 32'h0040_0018);

        // Random traffic with idle gaps, loads and links.
        for (int k = 0; k < 300; k++) begin
            t = nop();
            t.op        = 4'($urandom_range(0, 15));
            t.rs        = 5'($urandom_range(0, 31));
            t.rt        = 5'($urandom_range(0, 31));
            t.rd        = 5'($urandom_range(0, 31));
            t.reg_dst   = 1'($urandom_range(0, 1));
            t.alu_src   = 1'($urandom_range(0, 1));
            t.shift_amt = ($urandom_range(0, 3) == 0);
            t.imm       = 16'($urandom);
            t.imm_zext  = 1'($urandom_range(0, 1));
            t.shamt     = 5'($urandom_range(0, 31));
            t.link      = ($urandom_range(0, 15) == 0);
            t.pc        = $urandom;
            t.reg_write = ($urandom_range(0, 3) != 0);
            t.mem_to_reg = ($urandom_range(0, 4) == 0);
            t.ld_wait   = int'($urandom_range(0, 3));
            t.ld_data   = $urandom;
            if ($urandom_range(0, 4) == 0) idle(1);
            send(t);
        end
        idle(3);
        for (int i = 0; i < 32; i++) check_reg(i, model_rf[i]);
        check("final_register_v0", bus.register_v0, model_rf[2]);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // 16-bit instance: link wraps modulo 2^16.
        @(negedge clk);
        bus16.link = 1'b1; bus16.pc = 16'hFFFC; bus16.in_valid = 1'b1;
        #1;
        check("w16_in_ready", {31'h0, bus16.in_ready}, 32'h1);
        @(posedge clk);
        #1;
        check("w16_alu_out", {16'h0, bus16.alu_out}, 32'h0000_0004);
        check("w16_z", {31'h0, bus16.z}, 32'h0);
        @(negedge clk);
        bus16.in_valid = 1'b0; bus16.link = 1'b0; bus16.rs = 4'd15;
        @(negedge clk);
        #1;
        check("w16_r15", {16'h0, bus16.read_data_0}, 32'h0000_0004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/datapath_pipe.md
Name: datapath_pipe

Overview:
- Parametrised, registered successor to the single-cycle datapath.
- Contains the register file, operand select and extension, an ALU, a one-deep execute/writeback pipeline register, writeback forwarding, a link write and a memory-wait stall handshake.
- Sits between control decode (upstream valid/ready) and the data-memory interface.

Parameters:
- WIDTH, 32, datapath and register width in bits (power of two, at least 8).
- NREGS, 32, number of architectural registers (power of two); AW = clog2(NREGS).
- LINK_REG, NREGS-1, destination register index for link writes.
- LINK_OFFSET, 8, value added to pc for the link result.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; an instruction is issued when in_valid && in_ready.
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 LUI, 11-15 ADD.
- rs, rt, rd  in  AW  register indices.
- reg_dst  in  1  destination select: 1 = rd, 0 = rt.
- alu_src  in  1  operand B select: 1 = extended immediate or shamt, 0 = reg[rt].
- shift_amt  in  1  with alu_src, operand B = zero-extended shamt.
- imm  in  16  immediate.
- imm_zext  in  1  1 = zero-extend imm, 0 = sign-extend imm.
- shamt  in  5  shift amount.
- link  in  1  write pc+LINK_OFFSET to LINK_REG.
- pc  in  WIDTH  instruction address.
- reg_write  in  1  instruction writes a register.
- mem_to_reg  in  1  writeback data comes from mem_rdata.
- mem_ready  in  1  mem_rdata is valid this cycle.
- mem_rdata  in  WIDTH  load data.
- read_data_0  out  WIDTH  forwarded operand A, combinational (memory address base).
- out_valid  out  1  writeback stage occupied.
- alu_out  out  WIDTH  registered ALU or link result.
- z, n  out  1  registered zero flag and MSB of alu_out.
- register_v0  out  WIDTH  committed reg[2].

Behaviour:
- Reset (reset==0 at a clock edge):
  - All registers, alu_out, z and n clear to 0; out_valid clears to 0.
  - Any in-flight instruction is discarded with no write.
  - in_ready is 0 while reset is asserted.
- Issue cycle T, when in_valid && in_ready:
  - Read operands with forwarding, compute, and register {result, dest, we, mem_to_reg} at the end of T.
  - out_valid = 1 in cycle T+1.
- Writeback, WB cycle:
  - wb_data = mem_to_reg ? mem_rdata : alu_out.
  - The register file is written at the end of the WB cycle if we && dest != 0 && !(mem_to_reg && !mem_ready).
- Stall:
  - in_ready = !(out_valid && mem_to_reg && !mem_ready).
  - While stalled, the WB register holds, nothing is written, and no issue occurs.
  - When not stalled and nothing is issued, out_valid drops to 0 next cycle.
- Forwarding:
  - A source index equal to the WB dest, with WB we=1 and index != 0, takes wb_data instead of the register file.
  - The same applies to read_data_0.
  - register_v0 is never forwarded.
- Register 0:
  - Always reads 0; writes to it are dropped.
- Operand B:
  - alu_src=0: forwarded reg[rt].
  - shift_amt=1: zero-extended shamt.
  - Otherwise: imm, sign- or zero-extended per imm_zext.
- Shifts:
  - Shift operand B[clog2(WIDTH)-1:0] positions; SRA is arithmetic.
- Compares and LUI:
  - SLT is signed and SLTU unsigned; both produce 1 or 0 zero-extended.
  - LUI = imm << 16 (WIDTH >= 32), upper bits truncated.
- Overflow:
  - ADD and SUB wrap modulo 2^WIDTH; no trap.
- Link:
  - link=1 overrides: dest = LINK_REG, we = 1, result = pc + LINK_OFFSET mod 2^WIDTH, mem_to_reg forced 0.
- Flags:
  - z = (result == 0) and n = result[WIDTH-1], registered with alu_out.
- Simultaneous events:
  - Issue and writeback to the same register in the same cycle: the issuing instruction sees the forwarded wb_data.

Test Plan:
- Reset low for 2 cycles, then read all registers -> every register 0, out_valid=0, alu_out=0, in_ready=1 after release.
- Back-to-back dependency: ADDI r1 = r0 + 5 (imm 0x0005), then ADD r2 = r1 + r1 next cycle -> second alu_out = 10, register_v0 = 10 one cycle after its WB.
- Load stall: load to r3 with mem_ready low for 3 cycles, then mem_rdata = 0xDEADBEEF -> in_ready=0 for exactly 3 cycles, a following ADD r4 = r3 + r0 yields 0xDEADBEEF.
- Link at pc = 0x00400010 -> r31 = 0x00400018 and alu_out = 0x00400018; with WIDTH=16, pc 0xFFFC -> 0x0004.
- Write ADDI r0 = r0 + 7, then read r0 via ADD -> result 0, z=1, no forwarding of 7.
- Arithmetic edges:
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
  - imm 0xFFFF sign-extended -> 0xFFFFFFFF, zero-extended -> 0x0000FFFF.
  - ADD 0x7FFFFFFF + 1 -> 0x80000000 with n=1.
